// File: rtl/frac_pkg.sv
// Shared types and constants for the fractal scan controller.
// Coordinates default to Q4.28 two's complement.
package frac_pkg;

  localparam int unsigned FracM  = 4;
  localparam int unsigned FracF  = 28;
  localparam int unsigned FracW  = FracM + FracF;
  localparam int unsigned ColorW = 12;
  localparam int unsigned IterW  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapt,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/frac_color_map.sv
// Iteration count to RGB 4:4:4 pixel word; in-set points (iter == max) map to black.
module frac_color_map
  import frac_pkg::*;
(
  input  logic [IterW-1:0]  iter_i,
  input  logic [IterW-1:0]  max_it_i,
  output logic [ColorW-1:0] color_o
);

  always_comb begin
    if (iter_i == max_it_i) begin
      color_o = '0;
    end else begin
      color_o = {iter_i[3:0], iter_i[7:4], iter_i[11:8]};
    end
  end

endmodule

// File: rtl/frac_scan_ctrl.sv
// Raster-scan initiator for the fractal engine: steps coordinates, issues one engine
// start per pixel, and hands iteration results to the frame-buffer writer.
// Optional colour mapping of pixel words is enabled by defining FRAC_COLOR_MAP_EN.
module frac_scan_ctrl
  import frac_pkg::*;
#(
  parameter int unsigned W     = FracW,
  parameter int unsigned H_PIX = 320,
  parameter int unsigned V_PIX = 240,
  localparam int unsigned XW   = $clog2(H_PIX),
  localparam int unsigned YW   = $clog2(V_PIX)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [W-1:0]      cx0,
  input  logic [W-1:0]      cy0,
  input  logic [W-1:0]      delta,
  input  logic [15:0]       max_it,
  output logic              busy,
  output logic              done_tick,
  output logic              frac_start,
  output logic [W-1:0]      cx,
  output logic [W-1:0]      cy,
  output logic [15:0]       frac_max_it,
  input  logic              frac_ready,
  input  logic              frac_done_tick,
  input  logic [15:0]       iter,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic [ColorW-1:0] pix_data
);

  localparam logic [XW-1:0] XLast = XW'(H_PIX - 1);
  localparam logic [YW-1:0] YLast = YW'(V_PIX - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [W-1:0]    cx0_q, cx0_d, delta_q, delta_d;
  logic [15:0]     max_it_q, max_it_d, iter_q, iter_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            busy_q, busy_d, done_q, done_d, valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cx0_d    = cx0_q;
    delta_d  = delta_q;
    max_it_d = max_it_q;
    iter_d   = iter_q;
    x_d      = x_q;
    y_d      = y_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cx0_d    = cx0;
          delta_d  = delta;
          max_it_d = max_it;
          cx_d     = cx0;
          cy_d     = cy0;
          x_d      = '0;
          y_d      = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (frac_ready) state_d = StWait;
      end
      StWait: begin
        if (frac_done_tick) state_d = StCapt;
      end
      // iter is only valid one cycle after the engine's done tick
      StCapt: begin
        iter_d  = iter;
        state_d = StWrite;
      end
      StWrite: begin
        if (pix_ready) begin
          if (x_q == XLast && y_q == YLast) begin
            state_d = StDone;
          end else if (x_q == XLast) begin
            x_d     = '0;
            y_d     = y_q + 1'b1;
            cx_d    = cx0_q;
            cy_d    = cy_q - delta_q;
            state_d = StIssue;
          end else begin
            x_d     = x_q + 1'b1;
            cx_d    = cx_q + delta_q;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    valid_d = (state_d == StWrite);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      cx0_q    <= '0;
      delta_q  <= '0;
      max_it_q <= '0;
      iter_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      cx0_q    <= cx0_d;
      delta_q  <= delta_d;
      max_it_q <= max_it_d;
      iter_q   <= iter_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  // Start is a same-cycle response to frac_ready so the first issue lands in the ISSUE cycle.
  assign frac_start  = (state_q == StIssue) && frac_ready;
  assign busy        = busy_q;
  assign done_tick   = done_q;
  assign cx          = cx_q;
  assign cy          = cy_q;
  assign frac_max_it = max_it_q;
  assign pix_valid   = valid_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;

`ifdef FRAC_COLOR_MAP_EN
  frac_color_map u_color_map (
    .iter_i   (iter_q),
    .max_it_i (max_it_q),
    .color_o  (pix_data)
  );
`else
  logic unused_iter_hi;
  assign unused_iter_hi = ^iter_q[15:12];
  assign pix_data       = iter_q[11:0];
`endif

endmodule

// File: tb/tb_frac_scan_ctrl.sv
// Directed bench for frac_scan_ctrl on a 2x2 grid with a fixed-latency engine model.
module tb_frac_scan_ctrl;

  localparam int XW = 1;
  localparam int YW = 1;
`ifdef FRAC_COLOR_MAP_EN
  localparam logic [11:0] ExpSet = 12'h000;
  localparam logic [11:0] Exp123 = 12'h321;
`else
  localparam logic [11:0] ExpSet = 12'h010;
  localparam logic [11:0] Exp123 = 12'h123;
`endif

  logic clk = 1'b0;
  logic reset_n, start, frac_ready, frac_done_tick, pix_ready;
  logic [31:0] cx0, cy0, delta, cx, cy;
  logic [15:0] max_it, iter, frac_max_it;
  logic busy, done_tick, frac_start, pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [11:0] pix_data;

  int checks = 0;
  int errors = 0;

  // engine model state
  bit          eng_busy;
  int          eng_cnt;
  bit          ready_hold = 1'b0;
  logic [15:0] model_iter = 16'd0;
  int          n_start = 0;
  int          n_base = 0;
  logic [31:0] op_cx[64];
  logic [31:0] op_cy[64];

  // monitor results
  int npix, ndone, done_cyc, idle_cyc;
  int px[8], py[8];
  logic [11:0] pd[8];

  always #5 clk = ~clk;

  frac_scan_ctrl #(.W(32), .H_PIX(2), .V_PIX(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .cx0            (cx0),
    .cy0            (cy0),
    .delta          (delta),
    .max_it         (max_it),
    .busy           (busy),
    .done_tick      (done_tick),
    .frac_start     (frac_start),
    .cx             (cx),
    .cy             (cy),
    .frac_max_it    (frac_max_it),
    .frac_ready     (frac_ready),
    .frac_done_tick (frac_done_tick),
    .iter           (iter),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_data       (pix_data)
  );

  assign frac_ready = !eng_busy && !ready_hold;

  // Latency-3 engine; iter becomes valid the cycle after the done tick.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_busy       <= 1'b0;
      eng_cnt        <= 0;
      frac_done_tick <= 1'b0;
      iter           <= 16'd0;
    end else begin
      frac_done_tick <= 1'b0;
      if (frac_done_tick) iter <= model_iter;
      if (frac_start) begin
        if (n_start < 64) begin
          op_cx[n_start] = cx;
          op_cy[n_start] = cy;
        end
        n_start = n_start + 1;
        eng_busy <= 1'b1;
        eng_cnt  <= 3;
        iter     <= 16'hdead;
      end else if (eng_busy) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_busy       <= 1'b0;
          frac_done_tick <= 1'b1;
        end
      end
    end
  end

  task automatic kick(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input logic [15:0] m);
    cx0 = a; cy0 = b; delta = d; max_it = m;
    n_base = n_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_idle(output bit timeout);
    npix = 0; ndone = 0; done_cyc = -1; idle_cyc = -1; timeout = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (pix_valid && pix_ready && npix < 8) begin
        px[npix] = int'(pix_x); py[npix] = int'(pix_y); pd[npix] = pix_data;
        npix++;
      end
      if (done_tick) begin ndone++; done_cyc = c; end
      if (!busy) begin idle_cyc = c; timeout = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit timeout);
    timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (pix_valid) begin timeout = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
    cx0 = '0; cy0 = '0; delta = '0; max_it = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_tick); end
    checks++; if (frac_start !== 1'b0) begin errors++; $display("FAIL rst_fstart got %b want 0", frac_start); end
    checks++; if (cx !== 32'h0 || cy !== 32'h0) begin errors++; $display("FAIL rst_cxcy got %h %h want 0 0", cx, cy); end
    checks++; if (frac_max_it !== 16'h0) begin errors++; $display("FAIL rst_maxit got %h want 0", frac_max_it); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", pix_valid); end
    checks++; if (pix_x !== '0 || pix_y !== '0) begin errors++; $display("FAIL rst_xy got %h %h want 0 0", pix_x, pix_y); end
    checks++; if (pix_data !== 12'h0) begin errors++; $display("FAIL rst_data got %h want 000", pix_data); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame;
    logic [31:0] ecx[4] = '{32'hE0000000, 32'hE8000000, 32'hE0000000, 32'hE8000000};
    logic [31:0] ecy[4] = '{32'h10000000, 32'h10000000, 32'h08000000, 32'h08000000};
    int ex[4] = '{0, 1, 0, 1};
    int ey[4] = '{0, 0, 1, 1};
    bit to;
    pix_ready = 1'b1; model_iter = 16'd16;
    kick(32'hE0000000, 32'h10000000, 32'h08000000, 16'd16);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %b want 1", busy); end
    checks++; if (frac_start !== 1'b1) begin errors++; $display("FAIL frame_first_start got %b want 1", frac_start); end
    checks++; if (frac_max_it !== 16'd16) begin errors++; $display("FAIL frame_maxit got %h want 0010", frac_max_it); end
    run_to_idle(to);
    checks++; if (to) begin errors++; $display("FAIL frame_timeout got busy want idle"); end
    checks++; if (n_start - n_base != 4) begin errors++; $display("FAIL frame_nstart got %0d want 4", n_start - n_base); end
    checks++; if (npix != 4) begin errors++; $display("FAIL frame_npix got %0d want 4", npix); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (op_cx[n_base+i] !== ecx[i] || op_cy[n_base+i] !== ecy[i]) begin
        errors++;
        $display("FAIL frame_op%0d got %h,%h want %h,%h", i, op_cx[n_base+i], op_cy[n_base+i], ecx[i], ecy[i]);
      end
      checks++;
      if (px[i] != ex[i] || py[i] != ey[i] || pd[i] !== ExpSet) begin
        errors++;
        $display("FAIL frame_pix%0d got %0d,%0d,%h want %0d,%0d,%h", i, px[i], py[i], pd[i], ex[i], ey[i], ExpSet);
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL frame_ndone got %0d want 1", ndone); end
    checks++;
    if (idle_cyc != done_cyc + 1) begin
      errors++; $display("FAIL frame_busy_drop got %0d want %0d", idle_cyc, done_cyc + 1);
    end
  endtask

  task automatic test_backpressure;
    bit to;
    int base;
    pix_ready = 1'b0; model_iter = 16'h0123;
    kick(32'hE0000000, 32'h10000000, 32'h08000000, 16'd16);
    wait_valid(to);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL bp_wait got no valid want valid"); end
    base = n_start - n_base;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pix_valid !== 1'b1 || pix_x !== 1'b1 || pix_y !== 1'b0 || pix_data !== Exp123) begin
        errors++;
        $display("FAIL bp_stable%0d got %b,%h,%h,%h want 1,1,0,%h", k, pix_valid, pix_x, pix_y, pix_data, Exp123);
      end
      if (k == 5) pix_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (base != 2) begin errors++; $display("FAIL bp_base got %0d want 2", base); end
    checks++;
    if (pix_x !== 1'b0 || pix_y !== 1'b1) begin
      errors++; $display("FAIL bp_advance got %h,%h want 0,1", pix_x, pix_y);
    end
    run_to_idle(to);
    checks++; if (npix != 2 || ndone != 1) begin errors++; $display("FAIL bp_finish got %0d,%0d want 2,1", npix, ndone); end
    checks++; if (n_start - n_base != 4) begin errors++; $display("FAIL bp_nstart got %0d want 4", n_start - n_base); end
  endtask

  task automatic test_start_ignored;
    bit to;
    pix_ready = 1'b1; model_iter = 16'd5;
    kick(32'hE0000000, 32'h10000000, 32'h08000000, 16'd16);
    @(negedge clk);
    cx0 = 32'h40000000; cy0 = 32'h0; delta = 32'h1; max_it = 16'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_idle(to);
    checks++; if (n_start - n_base != 4) begin errors++; $display("FAIL ign_nstart got %0d want 4", n_start - n_base); end
    checks++; if (op_cx[n_base+1] !== 32'hE8000000) begin errors++; $display("FAIL ign_cx1 got %h want E8000000", op_cx[n_base+1]); end
    checks++; if (op_cx[n_base+2] !== 32'hE0000000) begin errors++; $display("FAIL ign_cx2 got %h want E0000000", op_cx[n_base+2]); end
    checks++; if (op_cy[n_base+3] !== 32'h08000000) begin errors++; $display("FAIL ign_cy3 got %h want 08000000", op_cy[n_base+3]); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_requeue got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit to;
    pix_ready = 1'b0; model_iter = 16'd3;
    kick(32'hE0000000, 32'h10000000, 32'h08000000, 16'd16);
    wait_valid(to);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got %b,%b want 0,0", busy, pix_valid); end
    checks++; if (cx !== 32'h0 || frac_max_it !== 16'h0) begin errors++; $display("FAIL mid_rst_regs got %h,%h want 0,0", cx, frac_max_it); end
    @(negedge clk);
    reset_n = 1'b1;
    pix_ready = 1'b1;
    kick(32'h11111111, 32'h22222222, 32'h01000000, 16'd7);
    run_to_idle(to);
    checks++;
    if (op_cx[n_base] !== 32'h11111111 || op_cy[n_base] !== 32'h22222222) begin
      errors++; $display("FAIL mid_first_op got %h,%h want 11111111,22222222", op_cx[n_base], op_cy[n_base]);
    end
    checks++; if (npix != 4 || px[0] != 0 || py[0] != 0) begin errors++; $display("FAIL mid_restart got %0d,%0d,%0d want 4,0,0", npix, px[0], py[0]); end
  endtask

  task automatic test_ready_hold;
    bit to;
    pix_ready = 1'b1; model_iter = 16'd2; ready_hold = 1'b1;
    kick(32'h00000000, 32'h00000000, 32'h00100000, 16'd8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (frac_start !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL hold_defer%0d got %b,%b want 0,1", k, frac_start, busy);
      end
      @(negedge clk);
    end
    ready_hold = 1'b0;
    #1;
    checks++; if (frac_start !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", frac_start); end
    @(negedge clk);
    checks++; if (frac_start !== 1'b0) begin errors++; $display("FAIL hold_single got %b want 0", frac_start); end
    checks++; if (n_start - n_base != 1) begin errors++; $display("FAIL hold_count got %0d want 1", n_start - n_base); end
    run_to_idle(to);
    checks++; if (npix != 4 || ndone != 1) begin errors++; $display("FAIL hold_finish got %0d,%0d want 4,1", npix, ndone); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_ready_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frac_scan_ctrl.md
# frac_scan_ctrl

Initiator for the fractal iteration engine. Walks a configurable H×V pixel grid in raster order and computes each pixel's complex coordinate incrementally. Issues one engine start per pixel, captures the iteration count, and delivers one pixel word per point to a frame-buffer writer over a valid/ready handshake. Sits between the host/control register block and the engine + frame-buffer write port.

## Interface
- W, 32, fixed-point word width of coordinates (Qm.f, two's complement)
- H_PIX, 320, pixels per row
- V_PIX, 240, rows per frame
- XW, $clog2(H_PIX), column index width (localparam)
- YW, $clog2(V_PIX), row index width (localparam)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- cx0, cy0  in  W  top-left coordinate, captured at start
- delta  in  W  per-pixel step, captured at start
- max_it  in  16  iteration limit, captured at start
- busy  out  1  high in every state except IDLE
- done_tick  out  1  one-cycle pulse after last pixel accepted
- frac_start  out  1  engine start pulse
- cx, cy  out  W  engine operands; valid while frac_start high
- frac_max_it  out  16  captured max_it, constant during frame
- frac_ready  in  1  engine idle
- frac_done_tick  in  1  engine completion pulse
- iter  in  16  engine iteration count
- pix_valid  out  1  pixel word valid
- pix_ready  in  1  writer accepts pixel word
- pix_x  out  XW  column of pixel word
- pix_y  out  YW  row of pixel word
- pix_data  out  12  pixel word

## Operation
- States: IDLE, ISSUE, WAIT, CAPT, WRITE, DONE.
- IDLE: on start, latch cx0/cy0/delta/max_it; set cx_reg=cx0, cy_reg=cy0, x=0, y=0; go to ISSUE.
- ISSUE: if frac_ready, assert frac_start for one cycle and go to WAIT. Otherwise hold.
- WAIT: on frac_done_tick, go to CAPT. The engine's iter settles one cycle after its done tick.
- CAPT: latch iter into iter_reg; go to WRITE.
- WRITE: pix_valid=1, with pix_x/pix_y/pix_data stable until pix_ready. On accept:
  - if x==H_PIX-1 and y==V_PIX-1: go to DONE.
  - else if x==H_PIX-1: x=0, y+=1, cx_reg=cx0_lat, cy_reg-=delta; go to ISSUE.
  - else: x+=1, cx_reg+=delta; go to ISSUE.
- DONE: done_tick=1 for one cycle; go to IDLE.
- Coordinate arithmetic is W-bit two's-complement with wrap-around and no saturation. Rows descend in imaginary axis (cy decreases).
- start while busy is ignored. Input changes after capture have no effect on the frame in progress.
- frac_done_tick outside WAIT is ignored.

## Timing
- Reset values: busy=0, done_tick=0, frac_start=0, cx=cy=0, frac_max_it=0, pix_valid=0, pix_x=0, pix_y=0, pix_data=0. Asynchronous reset mid-frame returns to IDLE immediately. The engine is reset from the same source.
- start high in IDLE at edge N: busy=1 from N+1; frac_start earliest at N+1 (ISSUE cycle, frac_ready=1).
- Per-pixel overhead with no backpressure: ISSUE(1) + engine latency + CAPT(1) + WRITE(1).
- pix_valid rises the cycle after CAPT. Once raised, it stays high until the pix_ready handshake completes.
- Simultaneous pix_ready and last-pixel accept: DONE on next cycle, done_tick one cycle later; busy drops the cycle after done_tick.

## Configuration
- FRAC_COLOR_MAP_EN defined:
  - pix_data = 12'h000 when iter_reg==frac_max_it (point in set).
  - otherwise pix_data = {iter_reg[3:0], iter_reg[7:4], iter_reg[11:8]} (RGB 4:4:4).
- Undefined: pix_data = iter_reg[11:0] raw.
- No other behaviour changes.

## Structure
- Shared package frac_pkg: state enum encoding, default W/M/F constants (Q4.28), color width (12).
- The colour mapping is a natural sub-module, frac_color_map: combinational iter→12-bit, instantiated only under FRAC_COLOR_MAP_EN.
- The coordinate stepper stays inline.

## Test plan
- H_PIX=2, V_PIX=2, cx0=0xE0000000, cy0=0x10000000, delta=0x08000000, engine model with latency 3 → frac_start operands in order (E0000000,10000000), (E8000000,10000000), (E0000000,08000000), (E8000000,08000000); pix_x/pix_y = 00,10,01,11; one done_tick.
- pix_ready held low 5 cycles on pixel 1 → pix_valid/pix_x/pix_data stable for 6 cycles; no second frac_start issued.
- Model returns iter=max_it=16 → with FRAC_COLOR_MAP_EN pix_data=000; without, pix_data=010. iter=0x123 with map enabled → pix_data=321.
- start pulsed during WAIT with different cx0 → ignored; operands follow the original frame.
- reset_n low during WRITE → all outputs at reset values asynchronously. After release, a fresh start begins at pixel (0,0).
- frac_ready low for 4 cycles in ISSUE → frac_start deferred until frac_ready=1, asserted exactly one cycle.
